// File: rtl/alu4_pkg.sv
// Shared types and constants for the 4-bit ALU execute/writeback controller.
// Used by alu4_regfile and alu4_exec_ctrl.
package alu4_pkg;

  localparam int NIB_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_R = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // ALU outputs captured at the end of EXEC
  typedef struct packed {
    logic [NIB_W-1:0] res;
    logic             ovf;
    logic             zero;
    logic             rcout;
    logic             cout;
  } alu_cap_t;

  function automatic logic [NIB_W-1:0] cap_to_flags(input alu_cap_t cap);
    logic [NIB_W-1:0] f;
    f         = '0;
    f[FLAG_C] = cap.cout;
    f[FLAG_R] = cap.rcout;
    f[FLAG_Z] = cap.zero;
    f[FLAG_V] = cap.ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu4_regfile.sv
// Nibble register file: NREGS x 4 flops, asynchronous active-high clear,
// one write port and three combinational read ports (A, B, debug).
module alu4_regfile
  import alu4_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NIB_W-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [NIB_W-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [NIB_W-1:0] rdata_b,
  input  logic [AW-1:0]    raddr_dbg,
  output logic [NIB_W-1:0] rdata_dbg
);

  logic [NIB_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/alu4_exec_ctrl.sv
// Execute/writeback controller around a combinational 4-bit ALU: serial,
// one instruction in flight. Optional feature macro: ALU4_NOWB_EN.
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on acceptance
// EXEC  | ALU outputs settle; result and flags captured at the edge
// WB    | done pulse; register and flag writeback at the edge
module alu4_exec_ctrl
  import alu4_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [AW-1:0]    instr_dst,
  input  logic [AW-1:0]    instr_srca,
  input  logic [AW-1:0]    instr_srcb,
  input  logic             instr_imm_en,
  input  logic [3:0]       instr_imm,
  input  logic             instr_nowb,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  output logic             alu_rcin,
  input  logic [3:0]       alu_res,
  input  logic             alu_cout,
  input  logic             alu_rcout,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  output logic [3:0]       flags,
  output logic             done,
  input  logic [AW-1:0]    dbg_addr,
  output logic [3:0]       dbg_data
);

  state_e           state_q, state_d;
  logic             accept;
  logic [3:0]       alu_op_q, alu_a_q, alu_b_q;
  logic [AW-1:0]    dst_q;
  alu_cap_t         cap_q;
  logic [3:0]       flags_q;
  logic [NIB_W-1:0] rd_a, rd_b;
  logic             wb_we;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are sampled from the register file at acceptance, so a source
  // equal to the destination always sees the pre-instruction value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      dst_q    <= '0;
    end else if (accept) begin
      alu_op_q <= instr_op;
      alu_a_q  <= rd_a;
      alu_b_q  <= instr_imm_en ? instr_imm : rd_b;
      dst_q    <= instr_dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= '0;
      flags_q <= '0;
    end else begin
      if (state_q == EXEC) begin
        cap_q.res   <= alu_res;
        cap_q.ovf   <= alu_ovf;
        cap_q.zero  <= alu_zero;
        cap_q.rcout <= alu_rcout;
        cap_q.cout  <= alu_cout;
      end
      if (state_q == WB) begin
        flags_q <= cap_to_flags(cap_q);
      end
    end
  end

`ifdef ALU4_NOWB_EN
  logic nowb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nowb_q <= 1'b0;
    end else if (accept) begin
      nowb_q <= instr_nowb;
    end
  end

  assign wb_we = (state_q == WB) && !nowb_q;
`else
  logic unused_nowb;

  assign unused_nowb = instr_nowb;
  assign wb_we       = (state_q == WB);
`endif

  alu4_regfile #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_we),
    .waddr     (dst_q),
    .wdata     (cap_q.res),
    .raddr_a   (instr_srca),
    .rdata_a   (rd_a),
    .raddr_b   (instr_srcb),
    .rdata_b   (rd_b),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign flags    = flags_q;
  assign alu_cin  = flags_q[FLAG_C];
  assign alu_rcin = flags_q[FLAG_R];

endmodule

// File: tb/tb_alu4_exec_ctrl.sv
// Directed, table-driven bench for alu4_exec_ctrl with a stub ALU driven by
// the bench; expected values are hand-computed per vector.
module tb_alu4_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0;
  logic [1:0] instr_dst = '0, instr_srca = '0, instr_srcb = '0;
  logic       instr_imm_en = 1'b0;
  logic [3:0] instr_imm = '0;
  logic       instr_nowb = 1'b0;
  logic [3:0] alu_op, alu_a, alu_b;
  logic       alu_cin, alu_rcin;
  logic [3:0] alu_res;
  logic       alu_cout = 1'b0, alu_rcout = 1'b0, alu_ovf = 1'b0, alu_zero = 1'b0;
  logic [3:0] flags;
  logic       done;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;

  logic [3:0] stub_res = '0;
  logic       stub_pass = 1'b0;
  assign alu_res = stub_pass ? alu_b : stub_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu4_exec_ctrl #(.NREGS(4), .AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_dst    (instr_dst),
    .instr_srca   (instr_srca),
    .instr_srcb   (instr_srcb),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .instr_nowb   (instr_nowb),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_rcin     (alu_rcin),
    .alu_res      (alu_res),
    .alu_cout     (alu_cout),
    .alu_rcout    (alu_rcout),
    .alu_ovf      (alu_ovf),
    .alu_zero     (alu_zero),
    .flags        (flags),
    .done         (done),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  typedef struct {
    logic [3:0] op;
    logic [1:0] dst, srca, srcb;
    logic       imm_en;
    logic [3:0] imm;
    logic       nowb;
    logic [3:0] s_res;
    logic       s_cout, s_rcout, s_ovf, s_zero;
    logic [3:0] e_a, e_b;
    logic       e_cin, e_rcin;
    logic [3:0] e_reg, e_flags;
  } vec_t;

  vec_t vecs[5];
  vec_t v_nowb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    wait_ready();
    instr_op     = v.op;
    instr_dst    = v.dst;
    instr_srca   = v.srca;
    instr_srcb   = v.srcb;
    instr_imm_en = v.imm_en;
    instr_imm    = v.imm;
    instr_nowb   = v.nowb;
    stub_res     = v.s_res;
    alu_cout     = v.s_cout;
    alu_rcout    = v.s_rcout;
    alu_ovf      = v.s_ovf;
    alu_zero     = v.s_zero;
    instr_valid  = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_op"},    32'(alu_op),      32'(v.op));
    chk({tag, "_exec_a"},     32'(alu_a),       32'(v.e_a));
    chk({tag, "_exec_b"},     32'(alu_b),       32'(v.e_b));
    chk({tag, "_exec_cin"},   32'(alu_cin),     32'(v.e_cin));
    chk({tag, "_exec_rcin"},  32'(alu_rcin),    32'(v.e_rcin));
    chk({tag, "_exec_ready"}, 32'(instr_ready), 32'd0);
    chk({tag, "_exec_done"},  32'(done),        32'd0);
    @(negedge clk);
    chk({tag, "_wb_done"},    32'(done),        32'd1);
    chk({tag, "_wb_ready"},   32'(instr_ready), 32'd0);
    chk({tag, "_wb_cin"},     32'(alu_cin),     32'(v.e_cin));
    dbg_addr = v.dst;
    @(negedge clk);
    chk({tag, "_reg"},        32'(dbg_data),    32'(v.e_reg));
    chk({tag, "_flags"},      32'(flags),       32'(v.e_flags));
    chk({tag, "_post_done"},  32'(done),        32'd0);
    chk({tag, "_post_ready"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic check_all_regs(input string tag, input logic [15:0] exp);
    logic [15:0] e;
    e = exp;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(e[i*4 +: 4]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dcnt, acc_cyc[4], done_cyc[4];
    logic rdy;
    logic saw_done;

    //          op    dst  sa   sb   ie  imm   nwb res   co rco ov z  e_a   e_b   ci rci reg   flags
    vecs[0] = '{4'h3, 2'd1, 2'd0, 2'd0, 1, 4'h5, 0, 4'hA, 1, 0, 0, 0, 4'h0, 4'h5, 0, 0, 4'hA, 4'b0001};
    vecs[1] = '{4'h4, 2'd2, 2'd1, 2'd1, 0, 4'h0, 0, 4'h3, 0, 1, 1, 0, 4'hA, 4'hA, 1, 0, 4'h3, 4'b1010};
    vecs[2] = '{4'hF, 2'd1, 2'd1, 2'd2, 0, 4'h0, 0, 4'h0, 1, 0, 0, 1, 4'hA, 4'h3, 0, 1, 4'h0, 4'b0101};
    vecs[3] = '{4'h7, 2'd3, 2'd2, 2'd3, 1, 4'hC, 0, 4'h9, 0, 1, 0, 0, 4'h3, 4'hC, 1, 0, 4'h9, 4'b0010};
    vecs[4] = '{4'h2, 2'd3, 2'd3, 2'd3, 0, 4'h0, 0, 4'h2, 1, 1, 1, 0, 4'h9, 4'h9, 0, 1, 4'h2, 4'b1011};
`ifdef ALU4_NOWB_EN
    v_nowb  = '{4'h8, 2'd2, 2'd0, 2'd0, 1, 4'h1, 1, 4'hF, 0, 0, 1, 0, 4'h0, 4'h1, 0, 0, 4'h0, 4'b1000};
`else
    v_nowb  = '{4'h8, 2'd2, 2'd0, 2'd0, 1, 4'h1, 1, 4'hF, 0, 0, 1, 0, 4'h0, 4'h1, 0, 0, 4'hF, 4'b1000};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check_all_regs("rst", 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end
    check_all_regs("tbl", 16'h2300);
    chk("hold_op", 32'({alu_op, alu_a, alu_b}), 32'h299);

    // Valid held high across two instructions; stub passes operand B through
    stub_pass = 1'b1;
    alu_cout = 0; alu_rcout = 0; alu_ovf = 0; alu_zero = 0;
    wait_ready();
    instr_op = 4'h1; instr_dst = 2'd0; instr_imm_en = 1; instr_imm = 4'h6;
    instr_valid = 1'b1;
    acc = 0; dcnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done && dcnt < 4) begin
        done_cyc[dcnt] = cyc;
        dcnt++;
      end
      rdy = instr_ready;
      @(posedge clk);
      #1;
      if (rdy && instr_valid && acc < 4) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == 1) begin
          instr_op = 4'h2; instr_dst = 2'd1; instr_imm = 4'hD;
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    chk("busy_accepts", 32'(acc), 32'd2);
    chk("busy_acc_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("busy_dones", 32'(dcnt), 32'd2);
    chk("busy_done0", 32'(done_cyc[0]), 32'd2);
    chk("busy_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
    check_all_regs("busy", 16'h23D6);
    stub_pass = 1'b0;

    // Reset asserted during EXEC
    wait_ready();
    instr_op = 4'h5; instr_dst = 2'd2; instr_imm_en = 1; instr_imm = 4'h7;
    stub_res = 4'hF; alu_cout = 1; alu_ovf = 1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_exec", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_flags", 32'(flags), 32'd0);
    check_all_regs("midrst", 16'h0000);

    // Write-suppressed instruction; flags still update
    run_vec("nowb", v_nowb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu4_exec_ctrl.md
Name: alu4_exec_ctrl

Overview:
- Execute/writeback controller that sits directly around the 4-bit ALU datapath.
- Accepts one instruction over a valid/ready handshake and reads operands from a small nibble register file.
- Drives opcode, operands and carry-ins to the combinational ALU, then captures its result and flags and writes them back.
- Serial, one instruction in flight; the flag register feeds chained multi-nibble arithmetic.

Parameters:
NREGS, 4, number of 4-bit registers (power of two, 2..8)
AW, 2, register address width, equal to clog2(NREGS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instr_op  in  4  ALU opcode, passed through unchanged
instr_dst  in  AW  destination register
instr_srca  in  AW  operand A register
instr_srcb  in  AW  operand B register
instr_imm_en  in  1  1: operand B comes from instr_imm, not the register file
instr_imm  in  4  immediate operand B
instr_nowb  in  1  suppress register write; used only with ALU4_NOWB_EN
alu_op  out  4  opcode to ALU
alu_a  out  4  operand A to ALU
alu_b  out  4  operand B to ALU
alu_cin  out  1  math carry-in; equals flag C
alu_rcin  out  1  rotate carry-in; equals flag R
alu_res  in  4  ALU result
alu_cout  in  1  ALU math carry-out
alu_rcout  in  1  ALU rotate carry-out
alu_ovf  in  1  ALU overflow
alu_zero  in  1  ALU zero
flags  out  4  {V,Z,R,C}
done  out  1  one-cycle pulse in the writeback cycle
dbg_addr  in  AW  debug read address
dbg_data  out  4  combinational read of regs[dbg_addr]

Behaviour:
- One clock (clk); reset is asynchronous, active high (rst). The reset polarity and synchronicity are fixed.
- Reset values:
  - FSM goes to IDLE.
  - All registers, flags, alu_op, alu_a and alu_b are 0.
  - done = 0, instr_ready = 1.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch the following, then go to EXEC:
    - alu_op <= instr_op
    - alu_a <= regs[srca]
    - alu_b <= imm_en ? instr_imm : regs[srcb]
    - dst, nowb
- EXEC:
  - instr_ready = 0; ALU outputs settle.
  - At the clock edge, capture alu_res, alu_cout, alu_rcout, alu_ovf and alu_zero into result registers.
  - Next state is WB.
- WB:
  - instr_ready = 0, done = 1.
  - At the clock edge, regs[dst] <= result and flags <= captured {V,Z,R,C}.
  - Next state is IDLE.
- Timing:
  - Acceptance edge = cycle 0.
  - Register and flag update are visible after the cycle-2 edge.
  - Next acceptance is possible at the cycle-3 edge, giving a throughput of 1 per 3 cycles.
- alu_cin and alu_rcin are combinational from the flag register. Flags change only in WB, so they are stable throughout EXEC.
- Operands are read at acceptance. srca = srcb = dst is legal and uses the old value.
- Handshake: once instr_valid is asserted, the source holds it and the instruction fields stable until accepted. In non-IDLE states the fields are don't-care.
- Flags update on every instruction, including nowb instructions.
- No register is hardwired to zero.
- dbg_data reflects the new value in the cycle after the WB edge.
- Reset asserted mid-operation:
  - The in-flight instruction is discarded with no writeback.
  - Flags and registers are cleared.
  - done is not pulsed.
- alu_op, alu_a and alu_b hold their last values after WB until the next acceptance.

Optional Feature:
- Macro: ALU4_NOWB_EN.
- When defined: an instruction with instr_nowb = 1 skips the register write in WB (compare/test style). Flags and the done pulse behave as normal.
- When undefined: instr_nowb is ignored and every instruction writes regs[dst].

Decomposition:
- Shared package alu4_pkg contains:
  - FSM state typedef {IDLE, EXEC, WB}
  - flag bit indices FLAG_C=0, FLAG_R=1, FLAG_Z=2, FLAG_V=3
  - NIB_W=4
- Sub-module alu4_regfile:
  - NREGS x 4 flops with asynchronous active-high clear.
  - One write port (we, waddr, wdata).
  - Three combinational read ports: A, B and debug.

Test Plan:
- Reset: assert rst for 2 cycles -> flags=0, all regs 0, instr_ready=1, done=0, dbg_data=0 for every address.
- Basic timing, stub ALU (res=4'hA, cout=1, rcout=0, ovf=0, zero=0): accept op=3, dst=1, imm_en=1, imm=5 at cycle 0 -> alu_op=3 and alu_b=5 during cycle 1; done in cycle 2; regs[1]=A and flags=4'b0001 after the cycle-2 edge; instr_ready low for cycles 1-2.
- Carry chaining: after the previous test (C=1), issue a second instruction -> alu_cin=1 throughout its EXEC. Stub then returns cout=0 -> C=0 after WB.
- Valid held during busy: keep instr_valid high continuously with two distinct instructions -> exactly one acceptance per 3 cycles, no instruction lost or duplicated, done pulses 3 cycles apart.
- Reset mid-operation: assert rst during EXEC -> regs[dst] is unchanged at 0, no done pulse, FSM in IDLE and instr_ready=1 after release.
- ALU4_NOWB_EN build: instr_nowb=1, dst=2, stub res=4'hF, zero=0 -> regs[2] stays 0 and flags update. In a build without the macro, the same stimulus gives regs[2]=F.
